pincheck_mc: RTL and testbench

Parametrised multi-channel pin/clock activity checker; next generation of the single-purpose pincheck used during board bring-up and production test. Counts edges per channel over a programmable window. Each channel is checked either for activity (toggling) or for a static level. The controller reads a per-channel pass vector plus raw edge counts through a select mux. Sits beside the controller in the controller clock domain; inputs come from the input registers or from external divide-by-2 toggle flops for fast clocks.

---
 rtl/pincheck_mc_pkg.sv | 22 ++
 rtl/pincheck_mc_ch.sv | 49 ++++
 rtl/pincheck_mc.sv | 129 ++++++++++++
 tb/tb_pincheck_mc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pincheck_mc_pkg.sv
// Shared types, default parameter values and width helper for the pincheck_mc
// multi-channel activity checker.
package pincheck_mc_pkg;

  localparam int DEF_NUM_CH      = 16;
  localparam int DEF_WIN_WIDTH   = 16;
  localparam int DEF_CNT_WIDTH   = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_EVAL    = 2'd3
  } state_e;

  // Select width for the readout mux; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pincheck_mc_ch.sv
// One monitored channel: async-input synchroniser, both-edge detector and
// saturating edge counter with clear and enable.
module pincheck_mc_ch
  import pincheck_mc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 nRST_i,
  input  logic                 sig_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_det;

  // The synchroniser is deliberately not touched by clr_i: edges already in
  // flight when a measurement starts still emerge and may be counted.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the shift chain does not collapse into one stage.
  always_ff @(posedge clk_i or negedge nRST_i) begin
    if (!nRST_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

  always_ff @(posedge clk_i or negedge nRST_i) begin
    if (!nRST_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && edge_det && (cnt_o != CNT_MAX)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pincheck_mc.sv
// Multi-channel pin/clock activity checker: counts edges per channel over a
// programmable window, then grades each channel as toggling or static.
module pincheck_mc
  import pincheck_mc_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int WIN_WIDTH   = DEF_WIN_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                           clk_i,
  input  logic                           nRST_i,
  input  logic                           run_i,
  input  logic [WIN_WIDTH-1:0]           window_len_i,
  input  logic [CNT_WIDTH-1:0]           min_edges_i,
  input  logic [NUM_CH-1:0]              mode_i,
  input  logic [NUM_CH-1:0]              sig_i,
  input  logic [sel_width(NUM_CH)-1:0]   cnt_sel_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           valid_o,
  output logic [NUM_CH-1:0]              status_o,
  output logic [CNT_WIDTH-1:0]           cnt_o
);

  state_e               state_q, state_d;
  logic                 run_q;
  logic                 run_rise;
  logic [WIN_WIDTH-1:0] win_q;
  logic [CNT_WIDTH-1:0] min_q;
  logic                 ch_clr;
  logic                 ch_en;
  logic [NUM_CH-1:0]    status_d;
  logic [CNT_WIDTH-1:0] cnt_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pincheck_mc_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_ch (
      .clk_i  (clk_i),
      .nRST_i (nRST_i),
      .sig_i  (sig_i[g]),
      .clr_i  (ch_clr),
      .en_i   (ch_en),
      .cnt_o  (cnt_arr[g])
    );
  end

  assign run_rise = run_i & ~run_q;

  // NOTE: every signal driven here gets a default first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != ST_IDLE);
    ch_clr  = (state_q == ST_CLEAR);
    ch_en   = (state_q == ST_MEASURE);
    unique case (state_q)
      ST_IDLE:    if (run_rise) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = run_i ? ST_MEASURE : ST_IDLE;
      ST_MEASURE: begin
        if (!run_i)              state_d = ST_IDLE;
        else if (win_q == '0)    state_d = ST_EVAL;
      end
      ST_EVAL:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Grade uses the live mode inputs; thresholds were captured at CLEAR.
  always_comb begin
    status_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      status_d[i] = mode_i[i] ? (cnt_arr[i] >= min_q) : (cnt_arr[i] == '0);
    end
  end

  always_ff @(posedge clk_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_i;
    end
  end

  // A window of W cycles loads W-1; a zero length wraps to the full range.
  always_ff @(posedge clk_i or negedge nRST_i) begin
    if (!nRST_i) begin
      win_q <= '0;
      min_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      win_q <= window_len_i - 1'b1;
      min_q <= min_edges_i;
    end else if ((state_q == ST_MEASURE) && (win_q != '0)) begin
      win_q <= win_q - 1'b1;
    end
  end

  // Old results are dropped the moment a new run is accepted, so an abort
  // always leaves status/valid cleared.
  always_ff @(posedge clk_i or negedge nRST_i) begin
    if (!nRST_i) begin
      done_o   <= 1'b0;
      valid_o  <= 1'b0;
      status_o <= '0;
    end else begin
      done_o <= 1'b0;
      if ((state_q == ST_IDLE) && run_rise) begin
        valid_o  <= 1'b0;
        status_o <= '0;
      end else if (state_q == ST_EVAL) begin
        done_o   <= 1'b1;
        valid_o  <= 1'b1;
        status_o <= status_d;
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cnt_sel_i) == i) cnt_o = cnt_arr[i];
    end
  end

endmodule

// File: tb/tb_pincheck_mc.sv
// Self-checking bench for pincheck_mc: a cycle-timeline model of DUT A checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pincheck_mc;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, run_b;
  logic [15:0] window_len;
  logic [3:0]  window_len_b;
  logic [7:0]  min_edges;
  logic [3:0]  mode;
  logic [3:0]  sig;
  logic [1:0]  cnt_sel;

  logic       busy_o, done_o, valid_o;
  logic [3:0] status_o;
  logic [7:0] cnt_o;
  logic       busy_b, done_b, valid_b;
  logic [3:0] status_b;
  logic [7:0] cnt_b;

  int total = 0;
  int bad   = 0;
  int tog_per = 0;

  pincheck_mc #(.NUM_CH(4), .WIN_WIDTH(16), .CNT_WIDTH(8), .SYNC_STAGES(S)) u_dut (
    .clk_i(clk), .nRST_i(rst_n), .run_i(run), .window_len_i(window_len),
    .min_edges_i(min_edges), .mode_i(mode), .sig_i(sig), .cnt_sel_i(cnt_sel),
    .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o), .status_o(status_o),
    .cnt_o(cnt_o)
  );

  pincheck_mc #(.NUM_CH(4), .WIN_WIDTH(4), .CNT_WIDTH(8), .SYNC_STAGES(S)) u_dut_w4 (
    .clk_i(clk), .nRST_i(rst_n), .run_i(run_b), .window_len_i(window_len_b),
    .min_edges_i(min_edges), .mode_i(mode), .sig_i(sig), .cnt_sel_i(cnt_sel),
    .busy_o(busy_b), .done_o(done_b), .valid_o(valid_b), .status_o(status_b),
    .cnt_o(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int k);
    k = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (done_o) begin
        k = i;
        break;
      end
    end
  endtask

  // ch0 stimulus: toggles every tog_per cycles (0 = hold).
  initial begin
    int c;
    c = 0;
    sig = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      c++;
      if (tog_per != 0 && (c % tog_per) == 0) sig[0] = ~sig[0];
    end
  end

  // Timeline model of DUT A: age counts cycles since the accepted run edge.
  logic [3:0] sq [$];
  int         m_cnt [4];
  bit         m_active;
  int         m_age, m_w;
  int         m_min;
  logic       m_prev_run, m_done, m_valid;
  logic [3:0] m_status;

  always @(posedge clk) begin
    if (!rst_n) begin
      sq = '{4'h0, 4'h0, 4'h0, 4'h0};
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_active = 0; m_age = 0; m_w = 0; m_min = 0;
      m_prev_run = 0; m_done = 0; m_valid = 0; m_status = 4'h0;
    end else begin
      sq.push_front(sig);
      void'(sq.pop_back());
      m_done = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == 1) begin
          for (int i = 0; i < 4; i++) m_cnt[i] = 0;
          m_w   = (window_len == 0) ? (1 << 16) : int'(window_len);
          m_min = int'(min_edges);
        end else if (m_age <= m_w + 1) begin
          for (int i = 0; i < 4; i++)
            if ((sq[S][i] ^ sq[S+1][i]) && m_cnt[i] < 255) m_cnt[i]++;
        end
        if (m_age <= m_w + 1 && !run) begin
          m_active = 0;
        end else if (m_age == m_w + 2) begin
          for (int i = 0; i < 4; i++)
            m_status[i] = mode[i] ? (m_cnt[i] >= m_min) : (m_cnt[i] == 0);
          m_valid  = 1'b1;
          m_done   = 1'b1;
          m_active = 0;
        end
      end else if (run && !m_prev_run) begin
        m_active = 1;
        m_age    = 0;
        m_valid  = 1'b0;
        m_status = 4'h0;
      end
      m_prev_run = run;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy",   busy_o,   m_active);
      check("cyc_done",   done_o,   m_done);
      check("cyc_valid",  valid_o,  m_valid);
      check("cyc_status", status_o, m_status);
      check("cyc_cnt",    cnt_o,    m_cnt[cnt_sel]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pulses;
    rst_n = 1'b0; run = 1'b0; run_b = 1'b0;
    window_len = 16'd64; window_len_b = 4'd0;
    min_edges = 8'd4; mode = 4'b1101; cnt_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid_status", {valid_o, done_o, status_o}, 6'h0);
    check("rst_cnt", cnt_o, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    step(3);

    // Basic: ch0 every 4 clk, W=64 -> done at t+67
    tog_per = 4; step(3);
    run = 1'b1;
    wait_done(200, k);
    check("t1_latency", k, 67);
    check("t1_status", status_o, 4'b0011);
    check("t1_valid", valid_o, 1);
    check("t1_cnt0_16pm1", (cnt_o >= 15 && cnt_o <= 17), 1);
    cnt_sel = 2'd1; #1;
    check("t1_cnt1", cnt_o, 0);
    cnt_sel = 2'd0;

    // Saturation: toggle every cycle, W=1000
    run = 1'b0; step(2);
    tog_per = 1; window_len = 16'd1000; step(2);
    run = 1'b1;
    wait_done(1100, k);
    check("t2_latency", k, 1003);
    check("t2_cnt_sat", cnt_o, 255);
    check("t2_status", status_o, 4'b0011);

    // Abort at MEASURE cycle 10 of W=100
    run = 1'b0; step(2);
    tog_per = 4; window_len = 16'd100; step(2);
    run = 1'b1; step(1);
    check("t3_clear_busy", busy_o, 1);
    check("t3_clear_valid", valid_o, 0);
    step(10);
    check("t3_meas_busy", busy_o, 1);
    run = 1'b0; step(1);
    check("t3_abort_busy", busy_o, 0);
    check("t3_abort_result", {valid_o, status_o}, 5'h0);
    pulses = 0;
    for (int i = 0; i < 120; i++) begin step(1); if (done_o) pulses++; end
    check("t3_no_done", pulses, 0);

    // Held run: single done; low-then-high restarts
    window_len = 16'd20; step(1);
    run = 1'b1;
    wait_done(60, k);
    check("t4_latency1", k, 23);
    pulses = 0;
    for (int i = 0; i < 500; i++) begin step(1); if (done_o) pulses++; end
    check("t4_no_restart", pulses, 0);
    run = 1'b0; step(2);
    run = 1'b1;
    wait_done(60, k);
    check("t4_latency2", k, 23);

    // run dropped in EVAL is ignored
    run = 1'b0; window_len = 16'd10; step(2);
    run = 1'b1; step(12);
    run = 1'b0; step(1);
    check("t5_eval_drop_done", {done_o, valid_o}, 2'b11);

    // min_edges=0: all toggle-mode channels pass
    tog_per = 0; min_edges = 8'd0; step(3);
    run = 1'b1;
    wait_done(50, k);
    check("t6_min0_status", status_o, 4'hF);
    run = 1'b0;

    // W=0 on the WIN_WIDTH=4 instance -> 19 cycles
    mode = 4'b0000; step(5);
    run_b = 1'b1;
    k = 41;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (done_b) begin k = i; break; end
    end
    check("t7_w0_latency", k, 19);
    check("t7_w0_result", {busy_b, valid_b, status_b}, 6'b01_1111);
    check("t7_w0_cnt", cnt_b, 0);
    run_b = 1'b0;

    // Async reset mid-MEASURE
    mode = 4'b1101; min_edges = 8'd4; tog_per = 2; window_len = 16'd200; step(2);
    run = 1'b1; step(30);
    check("t8_cnt_running", (cnt_o != 0), 1);
    @(negedge clk); #2;
    rst_n = 1'b0; run = 1'b0; #1;
    check("t8_async_busy", busy_o, 0);
    check("t8_async_cnt", cnt_o, 0);
    check("t8_async_flags", {done_o, valid_o, status_o}, 6'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    window_len = 16'd10;
    step(10);
    check("t8_idle_after_rst", busy_o, 0);
    run = 1'b1;
    wait_done(40, k);
    check("t8_fresh_latency", k, 13);
    run = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
